// File: rtl/reg_file_32x32.sv
// 32 x WIDTH register file: one synchronous write port, two combinational read
// ports built as LSB-first binary mux trees, optional write-to-read forwarding.

module reg_file_32x32_rd_port #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b0
) (
  input  logic                  rst_n,
  input  logic [31:0][WIDTH-1:0] regs,
  input  logic [4:0]            addr,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      data
);
  // Tree nodes laid out level by level: level k starts at 64 - (64 >> k).
  logic [WIDTH-1:0] node [0:62];
  logic [WIDTH-1:0] rd;
  logic             hit;

  genvar j, k;
  generate
    for (j = 0; j < 32; j++) begin : g_leaf
      assign node[j] = regs[j];
    end
    for (k = 0; k < 5; k++) begin : g_lvl
      localparam int IN  = 64 - (64 >> k);
      localparam int OUT = 64 - (32 >> k);
      for (j = 0; j < (32 >> (k + 1)); j++) begin : g_mux
        assign node[OUT+j] = addr[k] ? node[IN+2*j+1] : node[IN+2*j];
      end
    end
  endgenerate

  assign rd  = node[62];
  assign hit = we && (waddr != 5'd0) && (waddr == addr);

  // Gate forwarding with rst_n so reads stay 0 throughout reset.
  always_comb begin
    data = rd;
    if (!rst_n)              data = '0;
    else if (BYPASS && hit)  data = wdata;
  end
endmodule

module reg_file_32x32 #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [4:0]       raddr_a,
  input  logic [4:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);
  logic [WIDTH-1:0]       mem [1:31];
  logic [31:1]            wen;
  logic [31:0][WIDTH-1:0] regs;
  logic [1:0][4:0]        raddr;
  logic [1:0][WIDTH-1:0]  rdata;

  assign regs[0] = '0;

  genvar i;
  generate
    for (i = 1; i < 32; i++) begin : g_reg
      assign wen[i]  = we && (waddr == 5'(i));
      assign regs[i] = mem[i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mem[i] <= '0;
        else if (wen[i]) mem[i] <= wdata;
      end
    end
  endgenerate

  assign raddr   = {raddr_b, raddr_a};
  assign rdata_a = rdata[0];
  assign rdata_b = rdata[1];

  generate
    for (i = 0; i < 2; i++) begin : g_rd
      reg_file_32x32_rd_port #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_rd (
        .rst_n (rst_n),
        .regs  (regs),
        .addr  (raddr[i]),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .data  (rdata[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed bench: BYPASS=0 and BYPASS=1 instances share all inputs so each
// step checks both read-during-write behaviours against hand-computed values.

module tb_reg_file_32x32;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr, raddr_a, raddr_b;
  logic [31:0] wdata;
  logic [31:0] ra0, rb0, ra1, rb1;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  reg_file_32x32 #(.WIDTH(32), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra0), .rdata_b(rb0));

  reg_file_32x32 #(.WIDTH(32), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra1), .rdata_b(rb1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // we must never be X at a live rising edge
  always @(posedge clk) if (rst_n === 1'b1) begin
    total++;
    assert (!$isunknown(we)) passed++;
    else $error("FAIL we_x: observed %b expected 0/1", we);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  function automatic logic [31:0] sweep_val(input int i);
    return (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
  endfunction

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i); raddr_b = 5'(31 - i);
      #1;
      chk({tag, "_a0"}, ra0, sweep_val(i));
      chk({tag, "_b0"}, rb0, sweep_val(31 - i));
      chk({tag, "_a1"}, ra1, sweep_val(i));
      chk({tag, "_b1"}, rb1, sweep_val(31 - i));
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    // Reset: writes ignored and forwarding suppressed
    tick();
    we = 1'b1; waddr = 5'd5; wdata = 32'hA5A5A5A5; raddr_a = 5'd5; raddr_b = 5'd0;
    #1;
    chk("rst_byp_a1", ra1, 32'h0);
    chk("rst_a0", ra0, 32'h0);
    tick();
    chk("rst_wr_a0", ra0, 32'h0);
    we = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("rel_a0", ra0, 32'h0);

    // Async reset between edges
    wr(5'd5, 32'hDEADBEEF);
    raddr_a = 5'd5;
    #1 chk("r5_a0", ra0, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1 chk("async_a0", ra0, 32'h0);
    chk("async_a1", ra1, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    chk("async_hold", ra0, 32'h0);

    // Write all, then sweep both ports
    for (int i = 1; i < 32; i++) wr(5'(i), sweep_val(i));
    sweep("all");

    // Zero register ignores writes and is never forwarded
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr_a = 5'd0; raddr_b = 5'd0;
    #1 chk("z_pre_a0", ra0, 32'h0);
    chk("z_pre_a1", ra1, 32'h0);
    chk("z_pre_b1", rb1, 32'h0);
    tick();
    we = 1'b0;
    sweep("zero");

    // Same index on both ports, then we=0 hold with toggling data
    wr(5'd7, 32'h0000_0077);
    raddr_a = 5'd7; raddr_b = 5'd7;
    #1 chk("dp_a0", ra0, 32'h77);
    chk("dp_b0", rb0, 32'h77);
    chk("dp_b1", rb1, 32'h77);
    for (int c = 0; c < 10; c++) begin
      waddr = 5'(c + 1); wdata = (c % 2) ? 32'h0 : 32'hFFFFFFFF;
      tick();
    end
    #1 chk("hold_r7", ra0, 32'h77);
    wr(5'd7, sweep_val(7));
    sweep("hold");

    // Read-during-write, both BYPASS settings
    wr(5'd3, 32'h11111111);
    we = 1'b1; waddr = 5'd3; wdata = 32'h22222222; raddr_a = 5'd3; raddr_b = 5'd4;
    #1 chk("rdw_pre_a0", ra0, 32'h11111111);
    chk("rdw_pre_a1", ra1, 32'h22222222);
    chk("rdw_pre_b1", rb1, sweep_val(4));
    tick();
    we = 1'b0;
    chk("rdw_post_a0", ra0, 32'h22222222);
    chk("rdw_post_a1", ra1, 32'h22222222);
    chk("rdw_post_b0", rb0, sweep_val(4));

    // Reset asserted during a write cycle wins
    we = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D; raddr_a = 5'd9;
    #2 rst_n = 1'b0;
    tick();
    we = 1'b0;
    #1 rst_n = 1'b1;
    #1 chk("rst_wr_r9_a0", ra0, 32'h0);
    chk("rst_wr_r9_a1", ra1, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/reg_file_32x32.md
Name: reg_file_32x32

Overview:
- 32-entry × 32-bit general-purpose register file for the single-cycle datapath.
- Holds architectural state. One synchronous write port; two combinational read ports.
- Each read port selects one of the 32 stored words through a 32-to-1, 32-bit read mux. Outputs feed the ALU operand and store-data paths.
- Register 0 is hardwired to zero.

Parameters:
- WIDTH, 32, data width of each register and each data port.
- BYPASS, 0, 1 enables write-to-read forwarding on the read ports; 0 gives old-value reads during a write.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- we  input  1  write enable, sampled at rising clk
- waddr  input  5  write register index
- wdata  input  WIDTH  write data
- raddr_a  input  5  read port A register index
- raddr_b  input  5  read port B register index
- rdata_a  output  WIDTH  read port A data, combinational
- rdata_b  output  WIDTH  read port B data, combinational

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low.
  - When rst_n falls, all 32 registers clear to 0 immediately, with no clock edge required.
  - While rst_n is 0, writes are ignored. rdata_a and rdata_b read 0 for every address.
- Reset release: registers first accept writes on the first rising clk with rst_n = 1. Reset asserted mid-write-cycle wins: the register is 0 afterwards.
- Write decode:
  - waddr is decoded 5-to-32 into one-hot enables, gated by we.
  - At a rising clk with we = 1 and waddr != 0, reg[waddr] <= wdata.
  - All other registers hold their value.
- Register 0:
  - Never written; storage may be omitted.
  - Any read of index 0 returns 0, including when we = 1, waddr = 0 and wdata != 0.
- Reads:
  - Purely combinational, with zero-cycle latency from raddr_* to rdata_*.
  - Both ports are independent and may address the same register.
  - Select bit k of the address picks between pairs at tree level k (LSB first).
- Read-during-write, same index, BYPASS = 0:
  - rdata shows the pre-edge value until the rising edge.
  - It shows the new value after the edge, in the same cycle as register update.
- Read-during-write, same index, BYPASS = 1:
  - When we = 1, waddr != 0 and raddr == waddr, rdata = wdata combinationally before the edge.
  - Index 0 is never forwarded.
- X handling: we = X is not permitted at a rising edge. The bench checks that we is never X outside reset.
- No handshake and no stall: one write per cycle at most; reads are always valid.
- Timing: critical read path is 5 mux levels. The write path is a decoder plus register enable.

Test Plan:
- Async reset: write 0xDEADBEEF to r5. Drop rst_n between clock edges. rdata_a (raddr_a = 5) goes to 0x00000000 before the next rising clk.
- Write/read all: write reg i = 0x1000_0000 + i for i = 1..31, then sweep raddr_a 0..31 and raddr_b 31..0. Each port returns the written value, and index 0 returns 0.
- Zero register: we = 1, waddr = 0, wdata = 0xFFFFFFFF. raddr_a = 0 reads 0x00000000; no other register changes.
- Dual-port same index and we = 0 hold: raddr_a = raddr_b = 7 after writing 0x0000_0077. Both return 0x0000_0077. Holding we = 0 with wdata toggling for 10 cycles leaves all registers unchanged.
- Read-during-write with BYPASS = 0: r3 = 0x11111111; then we = 1, waddr = 3, wdata = 0x22222222, raddr_a = 3. Before the edge rdata_a = 0x11111111; after the edge it is 0x22222222.
- Read-during-write with BYPASS = 1: same stimulus as above. rdata_a = 0x22222222 before the edge. Same stimulus at index 0 reads 0.
